// File: rtl/mem_resp_if.sv
// mem_resp_if -- request/response bus between a controller and mem_resp.
//   req      : request, held by the controller until ack
//   we       : 1 = write, 0 = read (sampled with req)
//   addr     : word address (sampled with req)
//   wdata    : store data (sampled with req)
//   wait_cfg : wait states for this access, 0-3 (sampled with req)
//   rdata    : registered read data
//   ack      : one-cycle completion pulse
//   err      : out-of-range flag, meaningful only while ack=1
//   busy     : transaction in flight
interface mem_resp_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        wait_cfg;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, wait_cfg,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, wait_cfg,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_resp.sv
// mem_resp -- single-port word memory behind a req/ack handshake with a
// programmable number of wait states per access.
//   clk   : system clock, rising edge active
//   rst_f : asynchronous active-low reset (control, rdata and counter only;
//           the memory array keeps its contents)
//   bus   : mem_resp_if.slave (req/we/addr/wdata/wait_cfg in,
//           rdata/ack/err/busy out)
// Sequence: IDLE -accept-> [WAIT x wait_cfg] -> ACCESS -> RESP(ack) -> IDLE.
module mem_resp #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       rst_f,
  mem_resp_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_r;

  logic [31:0]       mem [DEPTH];

  logic              oor;
  logic [IDX_W-1:0]  idx;
  logic              accept;

  assign accept = (state == IDLE) && bus.req;
  assign oor    = ({1'b0, lat_addr} >= DEPTH_L);
  assign idx    = lat_addr[IDX_W-1:0];

  // Control registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          cnt_nxt   = bus.wait_cfg;
          state_nxt = (bus.wait_cfg != 2'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 2'd1;
        // Leave on the edge where the counter goes 1->0; the <= also keeps a
        // corrupted zero count from wrapping to 3.
        if (cnt <= 2'd1) begin
          cnt_nxt   = 2'd0;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: later changes on the bus cannot affect the access
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= bus.we;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
    end
  end

  // Memory write at the ACCESS->RESP edge; reset forces IDLE so an aborted
  // transaction never reaches this point.
  always_ff @(posedge clk) begin
    if ((state == ACCESS) && lat_we && !oor) begin
      mem[idx] <= lat_wdata;
    end
  end

  // Read data register: only reads update it
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rdata_r <= 32'd0;
    end else if ((state == ACCESS) && !lat_we) begin
      rdata_r <= oor ? 32'd0 : mem[idx];
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ack   = (state == RESP);
  assign bus.err   = (state == RESP) && oor;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp -- directed and randomized bench for mem_resp with a word-array
// reference model (memory contents, validity flags and expected rdata).
module tb_mem_resp;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 16;

  logic clk;
  logic rst_f;

  mem_resp_if #(.ADDR_W(ADDR_W)) bus ();

  mem_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_valid [DEPTH];
  logic [31:0] ref_rdata;
  bit          ref_rd_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction with req dropped right after acceptance.
  // ack is expected wait_cfg+1 edges after the accepting edge, i.e. in the
  // (wait_cfg+2)-th cycle counting the accepting cycle as the first.
  task automatic txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [1:0] wc, input bit scramble);
    int  k;
    bit  got;
    bit  oor;
    oor = (int'(a) >= DEPTH);
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = w;
    bus.addr     = a;
    bus.wdata    = d;
    bus.wait_cfg = wc;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    if (scramble) begin
      bus.we       = ~w;
      bus.addr     = a ^ 16'h0003;
      bus.wdata    = ~d;
      bus.wait_cfg = ~wc;
    end
    // model update
    if (w) begin
      if (!oor) begin
        ref_mem[a]   = d;
        ref_valid[a] = 1'b1;
      end
    end else begin
      if (oor) begin
        ref_rdata    = 32'd0;
        ref_rd_known = 1'b1;
      end else begin
        ref_rdata    = ref_mem[a];
        ref_rd_known = ref_valid[a];
      end
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 12) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        got = 1'b1;
      end else begin
        check("busy_inflight", {31'd0, bus.busy}, 32'd1);
        k++;
      end
    end
    check("ack_latency", 32'(k), 32'(int'(wc) + 1));
    check("ack_busy", {31'd0, bus.busy}, 32'd1);
    check("err", {31'd0, bus.err}, {31'd0, oor});
    if (ref_rd_known) check("rdata", bus.rdata, ref_rdata);
    @(negedge clk);
    check("ack_width", {31'd0, bus.ack}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_err", {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic        rw;
    logic [31:0] rd;
    logic [1:0]  rwc;
    bit          rsc;

    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
    ref_rdata    = 32'd0;
    ref_rd_known = 1'b1;

    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.wait_cfg = 2'd0;
    rst_f        = 1'b0;

    // Reset state
    #1;
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_f = 1'b1;

    // Zero-wait write/read of addr 5
    txn(1'b1, 16'd5, 32'hDEADBEEF, 2'd0, 1'b0);
    txn(1'b0, 16'd5, 32'h0, 2'd0, 1'b0);
    check("rd5_dead", bus.rdata, 32'hDEADBEEF);

    // Three wait states
    txn(1'b0, 16'd5, 32'h0, 2'd3, 1'b0);

    // A write leaves rdata alone
    txn(1'b1, 16'd0, 32'h0BADF00D, 2'd1, 1'b0);
    check("wr_keeps_rdata", bus.rdata, 32'hDEADBEEF);

    // Out-of-range write and read, addr 0 intact
    txn(1'b1, 16'h0100, 32'h12345678, 2'd0, 1'b0);
    txn(1'b0, 16'h0100, 32'h0, 2'd0, 1'b0);
    check("oor_rdata_zero", bus.rdata, 32'd0);
    txn(1'b0, 16'h0000, 32'h0, 2'd0, 1'b0);
    check("addr0_intact", bus.rdata, 32'h0BADF00D);

    // Continuous req, wait_cfg=1: ack after edges 2, 6, 10, 14
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = 1'b0;
    bus.addr     = 16'd5;
    bus.wait_cfg = 2'd1;
    ref_rdata    = ref_mem[5];
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("b2b_ack", {31'd0, bus.ack}, {31'd0, (k % 4) == 2});
      if ((k % 4) == 2) check("b2b_rdata", bus.rdata, ref_rdata);
      if (k == 14) bus.req = 1'b0;
      @(posedge clk);
    end
    repeat (2) @(negedge clk);
    check("b2b_idle", {31'd0, bus.busy}, 32'd0);

    // Reset during WAIT of a write to addr 7
    txn(1'b1, 16'd7, 32'hA5A5A5A5, 2'd0, 1'b0);
    txn(1'b0, 16'd5, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = 1'b1;
    bus.addr     = 16'd7;
    bus.wdata    = 32'h11111111;
    bus.wait_cfg = 2'd3;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    check("wait_busy", {31'd0, bus.busy}, 32'd1);
    rst_f = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_ack", {31'd0, bus.ack}, 32'd0);
    check("arst_err", {31'd0, bus.err}, 32'd0);
    check("arst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    ref_rdata    = 32'd0;
    ref_rd_known = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_ack_after_rst", {31'd0, bus.ack}, 32'd0);
    end
    txn(1'b0, 16'd7, 32'h0, 2'd0, 1'b0);
    check("addr7_intact", bus.rdata, 32'hA5A5A5A5);

    // Inputs changed after acceptance
    txn(1'b1, 16'd10, 32'h0A0A0A0A, 2'd0, 1'b0);
    txn(1'b1, 16'd9, 32'hCAFEF00D, 2'd2, 1'b1);
    txn(1'b0, 16'd9, 32'h0, 2'd0, 1'b0);
    check("latched_wdata", bus.rdata, 32'hCAFEF00D);
    txn(1'b0, 16'd10, 32'h0, 2'd0, 1'b0);
    check("scramble_addr_untouched", bus.rdata, 32'h0A0A0A0A);

    // Randomized traffic, including out-of-range addresses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'(240 + $urandom_range(0, 31));
      else                           ra = 16'($urandom_range(0, 15));
      rw  = 1'($urandom_range(0, 1));
      rd  = $urandom;
      rwc = 2'($urandom_range(0, 3));
      rsc = 1'($urandom_range(0, 1));
      txn(rw, ra, rd, rwc, rsc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
